// File: rtl/trigger_link_sequencer.sv
// trigger_link_sequencer: power-up/reset sequencer for four trigger fiber transmitters
module trigger_link_sequencer #(
  parameter int PLLRST_CYCLES = 16,
  parameter int GTXRST_CYCLES = 8,
  parameter int TIMEOUT       = 4000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_40,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       force_reset,
  input  logic [3:0] link_mask,
  input  logic [3:0] tx_pll_locked,
  input  logic [3:0] tx_resetdone,
  input  logic [3:0] tx_sync_done,
  output logic       txpll_rst,
  output logic       gtx_tx_rst,
  output logic       trg_rst,
  output logic [3:0] link_ready,
  output logic       data_valid,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_lost_cnt,
  output logic       timeout_err
);
  typedef enum logic [2:0] {
    IDLE, PLL_RST, WAIT_LOCK, GTX_RST, WAIT_DONE, WAIT_SYNC, READY, FAULT
  } st_t;
  st_t st, nxt;
  logic [11:0] s1, s2, timer;
  logic [3:0] lock_s, done_s, sync_s;
  logic all_lock, all_done, all_sync, restart, tmo, lost;
  assign {lock_s, done_s, sync_s} = s2;
  assign all_lock = &(lock_s | link_mask);
  assign all_done = &(done_s | link_mask);
  assign all_sync = &(sync_s | link_mask);
  assign state = st;
  // two-flop synchronizers for every asynchronous status bit
  always_ff @(posedge clk_40 or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {tx_pll_locked, tx_resetdone, tx_sync_done};
      s2 <= s1;
    end
  // next state: enable low beats force_reset, which beats timeout/lock loss, which beat progress
  always_comb begin
    restart = force_reset && st != IDLE;
    tmo = st inside {WAIT_LOCK, WAIT_DONE, WAIT_SYNC} && timer == 12'(TIMEOUT - 1);
    lost = st == READY && !all_lock;
    nxt = st;
    if (!enable) nxt = IDLE;
    else if (restart) nxt = PLL_RST;
    else if (tmo) nxt = retry_cnt == 2'(MAX_RETRIES) ? FAULT : PLL_RST;
    else if (lost) nxt = PLL_RST;
    else
      case (st)
        IDLE:      nxt = PLL_RST;
        PLL_RST:   nxt = timer == 12'(PLLRST_CYCLES - 1) ? WAIT_LOCK : st;
        WAIT_LOCK: nxt = all_lock ? GTX_RST : st;
        GTX_RST:   nxt = timer == 12'(GTXRST_CYCLES - 1) ? WAIT_DONE : st;
        WAIT_DONE: nxt = all_done ? WAIT_SYNC : st;
        WAIT_SYNC: nxt = all_sync ? READY : st;
        default:   nxt = st;
      endcase
  end
  // state, timer, counters and outputs registered from the next state so they change together
  always_ff @(posedge clk_40 or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      timer <= '0;
      txpll_rst <= 1'b1;
      gtx_tx_rst <= 1'b1;
      trg_rst <= 1'b1;
      link_ready <= '0;
      data_valid <= 1'b0;
      retry_cnt <= '0;
      lock_lost_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      st <= nxt;
      timer <= (nxt != st || restart) ? '0 : timer + 12'd1;
      txpll_rst <= nxt inside {IDLE, PLL_RST, FAULT};
      gtx_tx_rst <= nxt inside {IDLE, PLL_RST, WAIT_LOCK, GTX_RST, FAULT};
      trg_rst <= !(nxt inside {WAIT_SYNC, READY});
      data_valid <= nxt == READY;
      link_ready <= nxt == READY ? lock_s & ~link_mask : '0;
      timeout_err <= nxt == FAULT;
      if (!enable || restart) retry_cnt <= '0;
      else if (tmo && retry_cnt != 2'(MAX_RETRIES)) retry_cnt <= retry_cnt + 2'd1;
      else if (nxt == READY && st != READY) retry_cnt <= '0;
      if (enable && !restart && lost && lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
endmodule

// File: tb/tb_trigger_link_sequencer.sv
// tb_trigger_link_sequencer: directed self-checking bench for the link sequencer
module tb_trigger_link_sequencer;
  logic clk_40 = 1'b0, reset_n = 1'b0, enable = 1'b0, force_reset = 1'b0;
  logic [3:0] link_mask = '0, tx_pll_locked = '0, tx_resetdone = '0, tx_sync_done = '0;
  logic txpll_rst, gtx_tx_rst, trg_rst, data_valid, timeout_err;
  logic [3:0] link_ready;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] lock_lost_cnt;
  int n_chk = 0, n_fail = 0;
  int hist [8];
  int pll_hi, gtx_hi;
  trigger_link_sequencer dut (
    .clk_40(clk_40), .reset_n(reset_n), .enable(enable), .force_reset(force_reset),
    .link_mask(link_mask), .tx_pll_locked(tx_pll_locked), .tx_resetdone(tx_resetdone),
    .tx_sync_done(tx_sync_done), .txpll_rst(txpll_rst), .gtx_tx_rst(gtx_tx_rst),
    .trg_rst(trg_rst), .link_ready(link_ready), .data_valid(data_valid), .state(state),
    .retry_cnt(retry_cnt), .lock_lost_cnt(lock_lost_cnt), .timeout_err(timeout_err)
  );
  always #5 clk_40 = ~clk_40;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_state(input string tag, input logic [2:0] tgt, input int budget);
    int n = 0;
    while (state != tgt && n < budget) begin
      @(negedge clk_40);
      n++;
      hist[state]++;
      if (txpll_rst) pll_hi++;
      if (gtx_tx_rst && !txpll_rst && state != 3'd2) gtx_hi++;
    end
    chk(tag, state, tgt);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_rsts"}, {txpll_rst, gtx_tx_rst, trg_rst}, 3'b111);
    chk({tag, "_dv_lr"}, {data_valid, link_ready}, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_llc"}, lock_lost_cnt, 0);
    chk({tag, "_terr"}, timeout_err, 0);
  endtask
  task automatic restart_seq();
    @(negedge clk_40) enable = 1'b0;
    @(negedge clk_40) enable = 1'b1;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk_40);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk_40);
    chk("idle_hold", state, 0);
    foreach (hist[i]) hist[i] = 0;
    pll_hi = 0;
    gtx_hi = 0;
    enable = 1'b1;
    fork
      begin
        repeat (40) @(negedge clk_40);
        {tx_pll_locked, tx_resetdone, tx_sync_done} = '1;
      end
    join_none
    wait_state("bringup", 3'd6, 200);
    chk("pll_len", hist[1], 16);
    chk("txpll_hi", pll_hi, 16);
    chk("gtx_len", hist[3], 8);
    chk("gtx_hi", gtx_hi, 8);
    chk("ready_out", {data_valid, link_ready, txpll_rst, gtx_tx_rst, trg_rst}, 8'b1_1111_000);
    tx_pll_locked[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk_40);
      n++;
    end while (data_valid && n < 6);
    chk("loss_lat", n, 3);
    chk("loss_state", state, 1);
    chk("loss_cnt", lock_lost_cnt, 1);
    chk("loss_lr", link_ready, 0);
    tx_pll_locked[1] = 1'b1;
    wait_state("loss_recover", 3'd6, 100);
    chk("recover_lr", link_ready, 4'hF);
    @(negedge clk_40) enable = 1'b0;
    link_mask = 4'b1000;
    {tx_pll_locked, tx_resetdone, tx_sync_done} = {3{4'b0111}};
    @(negedge clk_40) enable = 1'b1;
    wait_state("mask_ready", 3'd6, 100);
    chk("mask_lr", {data_valid, link_ready}, 5'b1_0111);
    link_mask = 4'b0000;
    tx_pll_locked = 4'hF;
    tx_resetdone = 4'h0;
    restart_seq();
    wait_state("wdone", 3'd4, 100);
    force_reset = 1'b1;
    @(negedge clk_40);
    chk("force_in_wdone", state, 1);
    force_reset = 1'b0;
    wait_state("wdone2", 3'd4, 100);
    force_reset = 1'b1;
    enable = 1'b0;
    @(negedge clk_40);
    chk("prio_enable", state, 0);
    force_reset = 1'b0;
    tx_pll_locked = 4'h0;
    enable = 1'b1;
    wait_state("wlock", 3'd2, 40);
    n = 1;
    while (n < 5000) begin
      @(negedge clk_40);
      if (state != 3'd2) break;
      n++;
    end
    chk("timeout_len", n, 4000);
    chk("retry1", retry_cnt, 1);
    for (int r = 2; r <= 3; r++) begin
      wait_state("wlock_r", 3'd2, 40);
      wait_state("retry_pll", 3'd1, 4100);
      chk("retry_n", retry_cnt, r);
    end
    wait_state("fault", 3'd7, 4100);
    repeat (10) @(negedge clk_40);
    chk("fault_state", state, 7);
    chk("fault_out", {timeout_err, txpll_rst, gtx_tx_rst, trg_rst, data_valid, retry_cnt}, 7'b1111_0_11);
    force_reset = 1'b1;
    @(negedge clk_40);
    force_reset = 1'b0;
    chk("fault_exit", {state, timeout_err, retry_cnt}, {3'd1, 1'b0, 2'd0});
    {tx_pll_locked, tx_resetdone, tx_sync_done} = '1;
    wait_state("ll_ready", 3'd6, 100);
    for (int k = 0; k < 256; k++) begin
      tx_pll_locked[0] = 1'b0;
      wait_state("ll_drop", 3'd1, 10);
      tx_pll_locked[0] = 1'b1;
      wait_state("ll_back", 3'd6, 100);
    end
    chk("llc_sat", lock_lost_cnt, 255);
    restart_seq();
    wait_state("gtx", 3'd3, 100);
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("async");
    enable = 1'b0;
    @(negedge clk_40);
    chk_idle_outputs("async_hold");
    reset_n = 1'b1;
    repeat (5) @(negedge clk_40);
    chk("post_release", state, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trigger_link_sequencer.md
TRIGGER_LINK_SEQUENCER -- requirements
Module: trigger_link_sequencer

Interface
REQ-001 Parameter PLLRST_CYCLES, default 16, SHALL set the txpll_rst pulse length in clk_40 cycles.
REQ-002 Parameter GTXRST_CYCLES, default 8, SHALL set the gtx_tx_rst pulse length in cycles.
REQ-003 Parameter TIMEOUT, default 4000, SHALL set the max cycles spent in any WAIT_* state (12-bit timer).
REQ-004 Parameter MAX_RETRIES, default 3, SHALL set the consecutive timeouts allowed before FAULT.
REQ-005 clk_40  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-006 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 enable  in  1  SHALL be the level that runs the sequence; low forces IDLE.
REQ-008 force_reset  in  1  SHALL be the single-cycle request to restart the sequence.
REQ-009 link_mask  in  4  SHALL mark links to ignore when set (bit i = fiber i).
REQ-010 tx_pll_locked, tx_resetdone, tx_sync_done  in  4 each  SHALL be asynchronous per-link status inputs.
REQ-011 txpll_rst, gtx_tx_rst, trg_rst  out  1 each  SHALL be active-high resets to all four link transmitters.
REQ-012 link_ready  out  4, data_valid  out  1, state  out  3, retry_cnt  out  2, lock_lost_cnt  out  8, timeout_err  out  1 SHALL be registered status outputs.

Function
REQ-013 Each bit of each status input SHALL pass through a 2-flop synchronizer; every decision SHALL use synchronized values, giving 2-cycle input latency.
REQ-014 A condition "all X" SHALL mean (X_sync | link_mask) == 4'hF; link_mask = 4'hF SHALL make every wait condition immediately true.
REQ-015 States/encoding: IDLE=0, PLL_RST=1, WAIT_LOCK=2, GTX_RST=3, WAIT_DONE=4, WAIT_SYNC=5, READY=6, FAULT=7; state output SHALL show the current encoding.
REQ-016 IDLE: txpll_rst=gtx_tx_rst=trg_rst=1; enable=1 -> PLL_RST.
REQ-017 PLL_RST: txpll_rst=gtx_tx_rst=trg_rst=1 for exactly PLLRST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: txpll_rst=0, gtx_tx_rst=trg_rst=1; all locked -> GTX_RST.
REQ-019 GTX_RST: gtx_tx_rst=1 for exactly GTXRST_CYCLES cycles -> WAIT_DONE.
REQ-020 WAIT_DONE: gtx_tx_rst=0, trg_rst=1; all resetdone -> WAIT_SYNC.
REQ-021 WAIT_SYNC: trg_rst=0; all sync_done -> READY.
REQ-022 READY: all resets 0, data_valid=1, link_ready = locked_sync & ~link_mask, retry_cnt cleared on entry.
REQ-023 The timer SHALL clear on each state entry; reaching TIMEOUT in any WAIT_* state SHALL be a timeout: if retry_cnt == MAX_RETRIES -> FAULT, else retry_cnt+1 and -> PLL_RST.
REQ-024 In READY, loss of any unmasked synchronized lock SHALL increment lock_lost_cnt (saturating at 255) and -> PLL_RST next cycle, data_valid and link_ready dropping in that same cycle.
REQ-025 FAULT: all resets 1, timeout_err=1 (sticky); exit only via force_reset (-> PLL_RST) or enable=0 (-> IDLE), either clearing timeout_err and retry_cnt.
REQ-026 force_reset in any state except IDLE SHALL -> PLL_RST, clear retry_cnt and not count as a timeout.
REQ-027 Priority: enable=0 > force_reset > timeout/lock-loss > normal progress.
REQ-028 data_valid and link_ready SHALL be 0 in every state except READY.

Reset
REQ-029 reset_n low SHALL asynchronously force state=IDLE, txpll_rst=gtx_tx_rst=trg_rst=1, link_ready=0, data_valid=0, retry_cnt=0, lock_lost_cnt=0, timeout_err=0, timer=0, and clear the synchronizers.
REQ-030 Reset assertion mid-sequence SHALL abandon the sequence with no further output change until release; after release, IDLE is held while enable=0.

Verification
REQ-031 Normal bring-up: enable=1, all status inputs high at cycle 40, mask=0 -> txpll_rst high for 16 cycles, gtx_tx_rst for 8, READY reached, data_valid=1, link_ready=4'hF.
REQ-032 Masked link: mask=4'b1000, link 3 status held low -> READY reached, link_ready=4'b0111.
REQ-033 Lock never arrives: tx_pll_locked=0 -> three retries (retry_cnt 1,2,3), fourth timeout -> FAULT, timeout_err=1; force_reset -> PLL_RST, timeout_err=0.
REQ-034 Lock loss: in READY drop tx_pll_locked[1] -> 2-3 cycles later data_valid=0, lock_lost_cnt=1, state=PLL_RST; restore -> READY again.
REQ-035 Priority: force_reset and enable=0 in same cycle during WAIT_DONE -> IDLE; 256 lock losses -> lock_lost_cnt stays 255.
REQ-036 Async reset: reset_n pulsed low mid-GTX_RST (no clock edge) -> outputs immediately match REQ-029.
